// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit feeding the HI/LO registers.
// Latency: 33 clocks from the accepted start edge to hi/lo valid, coincident with done.
// Backpressure: busy holds the pipeline; start, mthi and mtlo are only honoured while idle.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] m;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc;    // partial product high half, or partial remainder
    logic [WIDTH-1:0] q;      // multiplier shifting out, or dividend shifting into quotient
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    // Operand conditioning for the launch edge.
    logic             is_signed;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;

    assign is_signed = ~op[0];
    assign sa        = is_signed & num1[WIDTH-1];
    assign sb        = is_signed & num2[WIDTH-1];
    assign abs1      = sa ? -num1 : num1;
    assign abs2      = sb ? -num2 : num2;

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] q_step;

    always_comb begin
        mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        div_shift = {acc, q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, m});
        div_diff  = div_shift - {1'b0, m};
        if (is_div) begin
            acc_step = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            q_step   = {q[WIDTH-2:0], div_ge};
        end else begin
            acc_step = mul_sum[WIDTH:1];
            q_step   = {mul_sum[0], q[WIDTH-1:1]};
        end
    end

    // Sign correction; a zero divisor forces an all-ones quotient, and negating the
    // dividend magnitude restores the original dividend as the remainder.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;

    always_comb begin
        prod     = {acc, q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = dz ? {WIDTH{1'b1}} : (neg_q ? -q : q);
        rem_fix  = neg_r ? -acc : acc;
        if (is_div) begin
            hi_res = rem_fix;
            lo_res = quo_fix;
        end else begin
            hi_res = prod_fix[2*WIDTH-1:WIDTH];
            lo_res = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            m      <= '0;
            acc    <= '0;
            q      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi) hi <= wd;
                    if (mtlo) lo <= wd;
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        cnt    <= CW'(WIDTH - 1);
                        acc    <= '0;
                        is_div <= op[1];
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        dz     <= op[1] && (num2 == '0);
                        m      <= op[1] ? abs2 : abs1;
                        q      <= op[1] ? abs1 : abs2;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    q   <= q_step;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    hi    <= hi_res;
                    lo    <= lo_res;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO pairs are queued at launch and checked on done.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] num1;
    logic [31:0] num2;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .num1  (num1),
        .num2  (num2),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_ops    = 0;

    always @(posedge clk) if (done === 1'b1) n_done++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for exactly one edge, then scrambles the operand inputs.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic push, input logic [31:0] eh, input logic [31:0] el);
        if (push) begin
            sb.push_back('{hi: eh, lo: el});
            n_ops++;
        end
        op    = o;
        num1  = a;
        num2  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        num1  = $urandom;
        num2  = $urandom;
        op    = 2'($urandom);
    endtask

    // Waits for done (bounded), optionally injecting a start / mthi while busy.
    task automatic wait_result(input string tag, input int start_at, input int mthi_at);
        int   c;
        bit   got;
        int   busy_bad;
        res_t e;
        got      = 1'b0;
        busy_bad = 0;
        for (c = 1; c <= 60; c++) begin
            start = (c == start_at);
            mthi  = (c == mthi_at);
            wd    = 32'h0000_AAAA;
            if (c == start_at) begin
                op   = 2'b00;
                num1 = 32'd9;
                num2 = 32'd9;
            end
            tick();
            start = 1'b0;
            mthi  = 1'b0;
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, "_latency"}, 64'(c), 64'd33);
            check({tag, "_busy_during"}, 64'(busy_bad), 64'd0);
            check({tag, "_busy_after"}, 64'(busy), 64'd0);
            check({tag, "_sb_pending"}, 64'(sb.size()), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_hi"}, 64'(hi), 64'(e.hi));
                check({tag, "_lo"}, 64'(lo), 64'(e.lo));
            end
        end
    endtask

    initial begin
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        op    = 2'b00;
        num1  = '0;
        num2  = '0;
        wd    = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
        check("multu_busy_e0", 64'(busy), 64'd1);
        wait_result("multu_max", 0, 0);

        launch(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        wait_result("mult_neg", 0, 0);

        launch(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
        wait_result("mult_min", 0, 0);

        launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_result("div_negnum", 0, 0);

        launch(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
        wait_result("div_negden", 0, 0);

        launch(2'b11, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
        wait_result("divu_zero", 0, 0);

        launch(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        wait_result("div_zero", 0, 0);

        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000);
        wait_result("div_ovf", 0, 0);

        launch(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
        wait_result("divu_ignore", 5, 10);

        mtlo = 1'b1;
        wd   = 32'h0000_0055;
        tick();
        mtlo = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h55);
        check("mtlo_hi_keep", 64'(hi), 64'd2);

        mthi = 1'b1;
        mtlo = 1'b1;
        wd   = 32'h0000_1234;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthilo_hi", 64'(hi), 64'h1234);
        check("mthilo_lo", 64'(lo), 64'h1234);

        launch(2'b01, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12);
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) rst = 1'b1;
            tick();
        end
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        d0  = n_done;
        repeat (40) tick();
        check("midrst_no_done", 64'(n_done), 64'(d0));
        check("midrst_idle", 64'(busy), 64'd0);

        mthi = 1'b1;
        wd   = 32'h0000_DEAD;
        launch(2'b01, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
        mthi = 1'b0;
        check("start_mthi_hi", 64'(hi), 64'hDEAD);
        wait_result("start_mthi", 0, 0);

        launch(2'b01, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30);
        wait_result("b2b_a", 0, 0);
        launch(2'b11, 32'd1000, 32'd10, 1'b1, 32'd0, 32'd100);
        wait_result("b2b_b", 0, 0);

        tick();
        tick();
        check("done_count", 64'(n_done), 64'(n_ops));
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
